alarm_scheduler: RTL and testbench
==================================

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter TIME_W, default 16, width of cur_time and stored deadlines.
REQ-002 Parameter DLY_W, default 8, width of each requester's delay operand.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cur_time  input  TIME_W  free-running time value supplied by the timekeeper.
REQ-006 req  input  2  per-requester arm request, level, held until granted.
REQ-007 delay0  input  DLY_W  requester 0 delay in cur_time ticks, sampled on grant.
REQ-008 delay1  input  DLY_W  requester 1 delay in cur_time ticks, sampled on grant.
REQ-009 cancel  input  2  per-requester disarm strobe, one cycle.
REQ-010 grant  output  2  one-cycle pulse, request accepted and slot armed; at most one bit high.
REQ-011 armed  output  2  slot armed status, registered.
REQ-012 expire  output  2  one-cycle pulse on slot deadline match, registered.

Function
REQ-013 Each requester owns one slot; slot states IDLE and ARMED, plus a stored deadline register of TIME_W bits.
REQ-014 Single shared arm path: at most one slot armed per cycle.
REQ-015 Eligible requester: req bit high and its slot IDLE, and its cancel bit low that cycle.
REQ-016 One eligible requester: grant it. Both eligible: grant the one indicated by a round-robin pointer.
REQ-017 Round-robin pointer resets to requester 0; after each grant it points to the other requester.
REQ-018 On grant, at the same edge: deadline = (cur_time + eff_delay) mod 2^TIME_W, slot -> ARMED, grant bit high for exactly that following cycle.
REQ-019 eff_delay = delay (zero-extended) when delay != 0; eff_delay = 1 when delay == 0.
REQ-020 Expiry test: slot ARMED and cur_time == deadline (equality; wrap-around of cur_time past 2^TIME_W-1 handled implicitly).
REQ-021 On expiry: slot -> IDLE, expire bit high exactly one cycle after the matching cur_time sample; no repeat pulse if cur_time stays stalled at the deadline.
REQ-022 Slot re-armable by a request the cycle after it returns to IDLE (earliest new grant one cycle after the expire pulse).
REQ-023 cancel on an ARMED slot: slot -> IDLE next edge, no expire; cancel on IDLE slot: no effect.
REQ-024 cancel and expiry match same cycle on same slot: cancel wins, no expire pulse.
REQ-025 req held high on an ARMED slot: no grant; request stays pending until slot IDLE.
REQ-026 Requester 0 and 1 expiring same cycle: both expire bits pulse together.
REQ-027 Deadline match and grant of the other slot same cycle: both occur independently.

Reset
REQ-028 rst_n low asynchronously forces: both slots IDLE, deadlines 0, grant 0, armed 0, expire 0, round-robin pointer 0.
REQ-029 Reset mid-operation: armed slots discarded, no expire pulse emitted for them after release.
REQ-030 First grant possible on first rising edge after rst_n deasserts.

Verification
REQ-031 cur_time=100, req=01, delay0=5 -> grant=01 next cycle, armed=01; expire=01 one cycle after cur_time==105, armed=00.
REQ-032 req=11 held from reset, both delays 3 -> grant=01 first, grant=10 next cycle; pointer then favours requester 0 again.
REQ-033 cur_time=65534, delay1=4 -> deadline 2; expire=10 after cur_time wraps to 2.
REQ-034 Arm slot 0 delay 10, assert cancel=01 at cur_time==deadline -> armed=00, expire never pulses.
REQ-035 delay0=0 at cur_time=50 -> deadline 51, expire after cur_time==51; cur_time frozen at 51 for 5 cycles -> exactly one expire pulse.
REQ-036 Arm both slots, pulse rst_n low between edges -> outputs 0 immediately, no expire after release.

Source files
------------

// File: rtl/alarm_scheduler_if.sv
// Arm/cancel/expiry signal bundle between a timekeeper-side client and alarm_scheduler.
interface alarm_scheduler_if #(
  parameter int TIME_W = 16,
  parameter int DLY_W  = 8
);
  logic [TIME_W-1:0] cur_time;
  logic [1:0]        req;
  logic [DLY_W-1:0]  delay0;
  logic [DLY_W-1:0]  delay1;
  logic [1:0]        cancel;
  logic [1:0]        grant;
  logic [1:0]        armed;
  logic [1:0]        expire;

  modport master (
    output cur_time, req, delay0, delay1, cancel,
    input  grant, armed, expire
  );

  modport slave (
    input  cur_time, req, delay0, delay1, cancel,
    output grant, armed, expire
  );
endinterface

// File: rtl/alarm_scheduler.sv
// Two-slot alarm scheduler: round-robin arm path, deadline = cur_time + delay,
// one-cycle expire pulse on an exact deadline match, cancel overrides expiry.
module alarm_scheduler #(
  parameter int TIME_W = 16,
  parameter int DLY_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alarm_scheduler_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } slot_state_t;

  slot_state_t       state    [2];
  logic [TIME_W-1:0] deadline [2];
  logic              rr_ptr;
  logic [1:0]        grant_q;
  logic [1:0]        expire_q;

  logic [1:0]        eligible;
  logic [1:0]        match;
  logic [1:0]        grant_sel;
  logic [TIME_W-1:0] arm_deadline;

  // A zero delay would match on the arming sample itself, so it is promoted to one tick.
  function automatic logic [TIME_W-1:0] eff_delay(input logic [DLY_W-1:0] dly);
    eff_delay = (dly == '0) ? TIME_W'(1) : TIME_W'(dly);
  endfunction

  function automatic logic [TIME_W-1:0] calc_deadline(input logic [TIME_W-1:0] now,
                                                      input logic [DLY_W-1:0]  dly);
    calc_deadline = now + eff_delay(dly);
  endfunction

  always_comb begin
    eligible     = 2'b00;
    match        = 2'b00;
    grant_sel    = 2'b00;
    arm_deadline = '0;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = bus.req[i] && (state[i] == IDLE) && !bus.cancel[i];
      match[i]    = (state[i] == ARMED) && (bus.cur_time == deadline[i]);
    end
    case (eligible)
      2'b01:   grant_sel = 2'b01;
      2'b10:   grant_sel = 2'b10;
      2'b11:   grant_sel = rr_ptr ? 2'b10 : 2'b01;
      default: grant_sel = 2'b00;
    endcase
    arm_deadline = calc_deadline(bus.cur_time, grant_sel[1] ? bus.delay1 : bus.delay0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i]    <= IDLE;
        deadline[i] <= '0;
      end
      rr_ptr   <= 1'b0;
      grant_q  <= 2'b00;
      expire_q <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Cancel is checked before the match so a same-cycle cancel suppresses expiry.
        if ((state[i] == ARMED) && bus.cancel[i]) begin
          state[i] <= IDLE;
        end else if (match[i]) begin
          state[i] <= IDLE;
        end else if (grant_sel[i]) begin
          state[i]    <= ARMED;
          deadline[i] <= arm_deadline;
        end
      end
      if (|grant_sel) begin
        rr_ptr <= grant_sel[0];
      end
      grant_q  <= grant_sel;
      expire_q <= match & ~bus.cancel;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.expire = expire_q;
  assign bus.armed  = {state[1] == ARMED, state[0] == ARMED};

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler with hand-computed expected outputs.
module tb_alarm_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   pulses;

  alarm_scheduler_if #(.TIME_W(16), .DLY_W(8)) bus ();

  alarm_scheduler #(.TIME_W(16), .DLY_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] t, input logic [1:0] r, input logic [1:0] c);
    bus.cur_time = t;
    bus.req      = r;
    bus.cancel   = c;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_in(16'd0, 2'b00, 2'b00);
    bus.delay0 = 8'd0;
    bus.delay1 = 8'd0;
    #23;
    chk("reset_grant", bus.grant, 2'b00);
    chk("reset_armed", bus.armed, 2'b00);
    chk("reset_expire", bus.expire, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic arm and expiry: deadline 105
    set_in(16'd100, 2'b01, 2'b00);
    bus.delay0 = 8'd5;
    tick();
    chk("a_grant", bus.grant, 2'b01);
    chk("a_armed", bus.armed, 2'b01);
    set_in(16'd101, 2'b00, 2'b00);
    tick();
    chk("a_no_early_expire", bus.expire, 2'b00);
    chk("a_grant_pulse_end", bus.grant, 2'b00);
    set_in(16'd105, 2'b00, 2'b00);
    tick();
    chk("a_expire", bus.expire, 2'b01);
    chk("a_disarmed", bus.armed, 2'b00);
    set_in(16'd106, 2'b00, 2'b00);
    tick();
    chk("a_expire_single", bus.expire, 2'b00);

    // Round robin from reset with both requesting, both deadlines 203
    rst_n = 1'b0;
    set_in(16'd200, 2'b11, 2'b00);
    bus.delay0 = 8'd3;
    bus.delay1 = 8'd3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rr_first", bus.grant, 2'b01);
    tick();
    chk("rr_second", bus.grant, 2'b10);
    chk("rr_both_armed", bus.armed, 2'b11);
    set_in(16'd203, 2'b00, 2'b00);
    tick();
    chk("both_expire", bus.expire, 2'b11);
    chk("both_idle", bus.armed, 2'b00);
    set_in(16'd204, 2'b11, 2'b00);
    tick();
    chk("rr_back_to_0", bus.grant, 2'b01);
    tick();
    chk("rr_then_1", bus.grant, 2'b10);
    set_in(16'd205, 2'b00, 2'b11);
    tick();
    chk("cancel_both", bus.armed, 2'b00);
    chk("cancel_both_no_exp", bus.expire, 2'b00);

    // Wrap-around: 65534 + 4 -> 2, plus a grant of slot 0 at the match cycle
    set_in(16'd65534, 2'b10, 2'b00);
    bus.delay1 = 8'd4;
    tick();
    chk("wrap_grant", bus.grant, 2'b10);
    set_in(16'd65535, 2'b00, 2'b00);
    tick();
    chk("wrap_no_exp_65535", bus.expire, 2'b00);
    set_in(16'd0, 2'b00, 2'b00);
    tick();
    chk("wrap_no_exp_0", bus.expire, 2'b00);
    set_in(16'd1, 2'b00, 2'b00);
    tick();
    chk("wrap_no_exp_1", bus.expire, 2'b00);
    set_in(16'd2, 2'b01, 2'b00);
    bus.delay0 = 8'd5;
    tick();
    chk("wrap_expire", bus.expire, 2'b10);
    chk("concurrent_grant", bus.grant, 2'b01);
    chk("concurrent_armed", bus.armed, 2'b01);
    set_in(16'd3, 2'b00, 2'b01);
    tick();
    chk("cancel_slot0", bus.armed, 2'b00);

    // Cancel on the deadline cycle beats expiry
    set_in(16'd300, 2'b01, 2'b00);
    bus.delay0 = 8'd10;
    tick();
    chk("c_grant", bus.grant, 2'b01);
    set_in(16'd310, 2'b00, 2'b01);
    tick();
    chk("c_armed_cleared", bus.armed, 2'b00);
    chk("c_no_expire", bus.expire, 2'b00);
    set_in(16'd311, 2'b00, 2'b00);
    tick();
    chk("c_no_late_expire", bus.expire, 2'b00);

    // Zero delay becomes one tick; stalled time yields a single pulse
    set_in(16'd50, 2'b01, 2'b00);
    bus.delay0 = 8'd0;
    tick();
    chk("z_grant", bus.grant, 2'b01);
    set_in(16'd51, 2'b00, 2'b00);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.expire == 2'b01) pulses++;
    end
    chk("z_single_pulse", 2'(pulses), 2'd1);
    chk("z_idle", bus.armed, 2'b00);

    // Held request on an armed slot waits, then re-arms right after expiry
    set_in(16'd70, 2'b01, 2'b00);
    bus.delay0 = 8'd1;
    tick();
    chk("h_grant", bus.grant, 2'b01);
    set_in(16'd71, 2'b01, 2'b00);
    tick();
    chk("h_expire", bus.expire, 2'b01);
    chk("h_no_grant_while_armed", bus.grant, 2'b00);
    set_in(16'd72, 2'b01, 2'b00);
    tick();
    chk("h_rearm", bus.grant, 2'b01);
    set_in(16'd73, 2'b00, 2'b01);
    tick();
    chk("h_cancel", bus.armed, 2'b00);

    // Asynchronous reset mid-operation discards armed slots
    set_in(16'd400, 2'b11, 2'b00);
    bus.delay0 = 8'd2;
    bus.delay1 = 8'd2;
    tick();
    tick();
    chk("r_both_armed", bus.armed, 2'b11);
    bus.req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_async_armed", bus.armed, 2'b00);
    chk("r_async_grant", bus.grant, 2'b00);
    chk("r_async_expire", bus.expire, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      bus.cur_time = 16'(401 + k);
      tick();
      if (bus.expire != 2'b00) pulses++;
    end
    chk("r_no_expire_after", 2'(pulses), 2'd0);
    chk("r_still_idle", bus.armed, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
